fetch_line_queue: RTL and testbench
===================================

// Module: fetch_line_queue
// PURPOSE
//  Parametrised instruction-fetch front end. Issues line-aligned I-cache requests, aligns each
//  returned line to the fetch PC and buffers lines in a FIFO for the instruction buffer.
//  Supports FETCH_WIDTH instructions per line, a valid/ready request handshake and redirect
//  flushes that discard in-flight data. Sits between the I-cache and the decode-side buffer.
// PARAMETERS
//  FETCH_WIDTH  2      instructions (32b) per cache line; power of 2, >=2
//  QUEUE_DEPTH  4      FIFO entries (lines); power of 2, >=2
//  RESET_PC     32'h0  PC loaded on reset
// PORTS
//  clk             in   1              clock, rising edge
//  reset           in   1              asynchronous, active-high
//  icache_addr     out  32             line-aligned request address (low log2(FW)+2 bits = 0)
//  icache_req      out  1              request valid
//  icache_ready    in   1              cache accepts request this cycle
//  icache_data     in   FW*32          line data; word k = instruction at line_base+4k
//  icache_valid    in   1              response valid; exactly 1 cycle after accepted request
//  redirect_valid  in   1              branch/exception redirect
//  redirect_pc     in   32             redirect target; bits [1:0] ignored (treated as 0)
//  out_valid       out  FW             per-slot valid, contiguous from slot 0
//  out_instr       out  FW*32          slot k = k-th instruction from the fetch PC, compacted
//  out_ready       in   1              consumer pops the whole head entry
//  queue_count     out  $clog2(QD+1)   occupied entries
//  out_pc          out  32             head entry slot-0 PC (FETCH_PC_OUT_EN only)
// BEHAVIOUR
//  - Reset (async): pc=RESET_PC, FIFO empty, no in-flight request, epoch=0; all outputs 0.
//    icache_req may assert in the first cycle after reset deasserts.
//  - Credit: icache_req = !redirect_valid && (queue_count + inflight) < QUEUE_DEPTH.
//  - Accept (icache_req && icache_ready): set inflight=1, latch slot offset
//    off=pc[log2(FW)+1:2] and the current epoch; pc <= line_base + FW*4 (wraps mod 2^32).
//  - Response: on icache_valid with a matching epoch, push {line, off}; inflight clears.
//    A stale-epoch response is dropped and still clears inflight.
//  - Output: head entry shifted down by off: out_instr slot k = word[off+k];
//    out_valid = FW-off ones from bit 0; remaining slots read 0. Empty FIFO: out_valid=0, out_instr=0.
//  - Pop when out_ready && FIFO non-empty. Simultaneous push and pop leaves the count unchanged.
//    Credit rule prevents overflow; popping when empty is a no-op.
//  - Latency: accept at cycle N, data at N+1, out_valid at N+2 (no bypass).
//  - Redirect (highest priority): flush the FIFO (count=0, same-edge pop ignored), toggle epoch,
//    pc <= {redirect_pc[31:2],2'b00}, no request that cycle. A response arriving in the redirect
//    cycle or later with the old epoch is discarded. Back-to-back redirects: last one wins.
//  - Reset asserted mid-operation clears all state immediately; in-flight data is lost.
// CONFIGURATION
//  FETCH_PC_OUT_EN defined: FIFO also stores line_base+4*off per entry and drives out_pc
//    (0 when empty). Required for PC-relative decode.
//  FETCH_PC_OUT_EN undefined: out_pc port absent, no PC storage in the FIFO.
// TESTING
//  1 FW=2,QD=4, release reset, ready=1, line@0={B,A} -> addr 0x0, then 0x8; at N+2
//    out_valid=2'b11, out_instr={B,A}.
//  2 Redirect pc=0x104 -> next addr 0x100, line {D,C} -> out_valid=2'b01, slot0=D,
//    next addr 0x108.
//  3 out_ready=0, ready=1 -> 4 lines fill, queue_count=4, icache_req=0; one pop ->
//    icache_req=1 next cycle.
//  4 Redirect in the cycle after accept -> stale response dropped, queue_count stays 0,
//    first line pushed is from the target.
//  5 Assert reset mid-stream with a full FIFO -> out_valid=0, queue_count=0, icache_req=0
//    asynchronously; refetch from RESET_PC.
//  6 FETCH_PC_OUT_EN, redirect 0x204 -> out_pc=0x204, then 0x208 for the next line.

Source files
------------

// File: rtl/fetch_line_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_line_queue
// Description : Instruction-fetch front end. Issues line-aligned I-cache
//               requests, aligns returned lines to the fetch PC and queues
//               them for decode. Optional macro FETCH_PC_OUT_EN adds a per-entry
//               PC and the out_pc port.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_line_queue #(
  parameter int          FETCH_WIDTH = 2,
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                             clk,
  input  logic                             reset,
  output logic [31:0]                      icache_addr,
  output logic                             icache_req,
  input  logic                             icache_ready,
  input  logic [FETCH_WIDTH*32-1:0]        icache_data,
  input  logic                             icache_valid,
  input  logic                             redirect_valid,
  input  logic [31:0]                      redirect_pc,
  output logic [FETCH_WIDTH-1:0]           out_valid,
  output logic [FETCH_WIDTH*32-1:0]        out_instr,
  input  logic                             out_ready,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count
`ifdef FETCH_PC_OUT_EN
  ,
  output logic [31:0]                      out_pc
`endif
);

  localparam int          c_OFF_W      = $clog2(FETCH_WIDTH);
  localparam int          c_LSB        = c_OFF_W + 2;
  localparam int          c_PTR_W      = $clog2(QUEUE_DEPTH);
  localparam int          c_CNT_W      = $clog2(QUEUE_DEPTH + 1);
  localparam int          c_LW         = FETCH_WIDTH * 32;
  localparam logic [31:0] c_LINE_BYTES = 32'(FETCH_WIDTH * 4);
  localparam logic [31:0] c_OFF_MASK   = 32'(FETCH_WIDTH * 4 - 1);
  localparam logic [c_OFF_W:0] c_FW    = (c_OFF_W + 1)'(FETCH_WIDTH);

  logic [31:0]        r_pc;
  logic               r_inflight;
  logic               r_epoch;
  logic               r_req_epoch;
  logic [c_OFF_W-1:0] r_req_off;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_LW-1:0]    r_fifo_data [QUEUE_DEPTH];
  logic [c_OFF_W-1:0] r_fifo_off  [QUEUE_DEPTH];

  logic [31:0]        w_line_base;
  logic               w_credit;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic [c_LW-1:0]    w_head_data;
  logic [c_OFF_W-1:0] w_head_off;
  logic [c_LW-1:0]    w_shifted;

  assign w_line_base = r_pc & ~c_OFF_MASK;
  assign w_credit    = (32'(r_count) + 32'(r_inflight)) < 32'(QUEUE_DEPTH);
  // Reset gates the request so it is low asynchronously while reset is held.
  assign icache_req  = !reset && !redirect_valid && w_credit;
  assign icache_addr = reset ? 32'h0 : w_line_base;
  assign w_accept    = icache_req && icache_ready;
  assign w_push      = icache_valid && r_inflight && !redirect_valid &&
                       (r_req_epoch == r_epoch);
  assign w_empty     = (r_count == '0);
  assign w_pop       = out_ready && !w_empty && !redirect_valid;
  assign queue_count = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc        <= RESET_PC & 32'hFFFF_FFFC;
      r_inflight  <= 1'b0;
      r_epoch     <= 1'b0;
      r_req_epoch <= 1'b0;
      r_req_off   <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      if (w_accept) begin
        r_inflight  <= 1'b1;
        r_req_epoch <= r_epoch;
        r_req_off   <= r_pc[c_LSB-1:2];
      end else if (icache_valid) begin
        r_inflight  <= 1'b0;
      end

      if (redirect_valid) begin
        r_epoch  <= ~r_epoch;
        r_pc     <= redirect_pc & 32'hFFFF_FFFC;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_accept) r_pc <= w_line_base + c_LINE_BYTES;
        if (w_push)   r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
        if (w_pop)    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + c_CNT_W'(1);
          2'b01:   r_count <= r_count - c_CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Storage needs no reset: the output path is gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= icache_data;
      r_fifo_off[r_wr_ptr]  <= r_req_off;
    end
  end

  assign w_head_data = r_fifo_data[r_rd_ptr];
  assign w_head_off  = r_fifo_off[r_rd_ptr];
  assign w_shifted   = w_head_data >> {w_head_off, 5'b0};
  assign out_instr   = w_empty ? '0 : w_shifted;

  generate
    for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_slot
      localparam logic [c_OFF_W:0] c_K = (c_OFF_W + 1)'(k);
      assign out_valid[k] = !w_empty && (({1'b0, w_head_off} + c_K) < c_FW);
    end
  endgenerate

`ifdef FETCH_PC_OUT_EN
  logic [31:0] r_req_pc;
  logic [31:0] r_fifo_pc [QUEUE_DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_req_pc <= 32'h0;
    else if (w_accept) r_req_pc <= r_pc;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo_pc[r_wr_ptr] <= r_req_pc;
  end

  assign out_pc = w_empty ? 32'h0 : r_fifo_pc[r_rd_ptr];
`else
  // Without the PC option the queue carries only line data and slot offset.
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_line_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_line_queue
// Description : Scoreboard bench for fetch_line_queue with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_line_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] icache_addr;
  logic        icache_req;
  logic        icache_ready;
  logic [63:0] icache_data;
  logic        icache_valid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  out_valid;
  logic [63:0] out_instr;
  logic        out_ready;
  logic [2:0]  queue_count;
`ifdef FETCH_PC_OUT_EN
  logic [31:0] out_pc;
`endif

  fetch_line_queue #(
    .FETCH_WIDTH(2),
    .QUEUE_DEPTH(4),
    .RESET_PC   (32'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .icache_addr   (icache_addr),
    .icache_req    (icache_req),
    .icache_ready  (icache_ready),
    .icache_data   (icache_data),
    .icache_valid  (icache_valid),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_instr     (out_instr),
    .out_ready     (out_ready),
    .queue_count   (queue_count)
`ifdef FETCH_PC_OUT_EN
    ,
    .out_pc        (out_pc)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  v;
    logic [63:0] ins;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expected entry whenever the DUT is about to pop its head.
  always @(negedge clk) begin
    #2;
    if (!reset && out_ready && !redirect_valid && out_valid != 2'b00) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_entry: got %0h expected none", out_instr);
      end else begin
        e = sb.pop_front();
        chk("out_valid", 64'(out_valid), 64'(e.v));
        chk("out_instr", out_instr, e.ins);
`ifdef FETCH_PC_OUT_EN
        chk("out_pc", 64'(out_pc), 64'(e.pc));
`endif
      end
    end
  end

  // One request/response handshake; the cache returns word k = 0xC0DE0000|addr+4k.
  task automatic accept_line(input logic [31:0] a, input logic [1:0] v,
                             input logic [63:0] ins, input logic [31:0] pcv,
                             input bit push, input bit chk_lat);
    int n = 0;
    @(negedge clk);
    while (!icache_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_wait", 64'(icache_req), 64'd1);
    chk("icache_addr", 64'(icache_addr), 64'(a));
    if (push) sb.push_back('{v: v, ins: ins, pc: pcv});
    icache_ready = 1'b1;
    @(negedge clk);
    icache_ready = 1'b0;
    icache_valid = 1'b1;
    icache_data  = {32'hC0DE_0000 | (a + 32'd4), 32'hC0DE_0000 | a};
    if (chk_lat) chk("latency_no_bypass", 64'(out_valid), 64'd0);
    @(negedge clk);
    icache_valid = 1'b0;
    icache_data  = 64'h0;
  endtask

  initial begin
    reset = 1'b1; icache_ready = 1'b0; icache_data = 64'h0; icache_valid = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(queue_count), 64'd0);
    chk("rst_req", 64'(icache_req), 64'd0);
    chk("rst_addr", 64'(icache_addr), 64'd0);
    reset = 1'b0;

    // Aligned lines from reset PC
    out_ready = 1'b1;
    accept_line(32'h0, 2'b11, {32'hC0DE_0004, 32'hC0DE_0000}, 32'h0, 1'b1, 1'b1);
    accept_line(32'h8, 2'b11, {32'hC0DE_000C, 32'hC0DE_0008}, 32'h8, 1'b1, 1'b0);

    // Redirect into the middle of a line
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h104;
    #1 chk("redirect_blocks_req", 64'(icache_req), 64'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    accept_line(32'h100, 2'b01, {32'h0, 32'hC0DE_0104}, 32'h104, 1'b1, 1'b1);
    accept_line(32'h108, 2'b11, {32'hC0DE_010C, 32'hC0DE_0108}, 32'h108, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("drain_after_redirect", 64'(sb.size()), 64'd0);

    // Fill the queue with no consumer; credit must stop requests
    out_ready = 1'b0;
    accept_line(32'h110, 2'b11, {32'hC0DE_0114, 32'hC0DE_0110}, 32'h110, 1'b1, 1'b0);
    accept_line(32'h118, 2'b11, {32'hC0DE_011C, 32'hC0DE_0118}, 32'h118, 1'b1, 1'b0);
    accept_line(32'h120, 2'b11, {32'hC0DE_0124, 32'hC0DE_0120}, 32'h120, 1'b1, 1'b0);
    accept_line(32'h128, 2'b11, {32'hC0DE_012C, 32'hC0DE_0128}, 32'h128, 1'b1, 1'b0);
    chk("full_count", 64'(queue_count), 64'd4);
    chk("full_no_req", 64'(icache_req), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("pop_count", 64'(queue_count), 64'd3);
    chk("pop_req_back", 64'(icache_req), 64'd1);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("drain_count", 64'(queue_count), 64'd0);

    // Redirect in the response cycle: stale line must be dropped
    begin
      int n = 0;
      while (!icache_req && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("stale_addr", 64'(icache_addr), 64'h130);
    icache_ready = 1'b1;
    @(negedge clk);
    icache_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h302;
    icache_valid = 1'b1; icache_data = {32'hC0DE_0134, 32'hC0DE_0130};
    @(negedge clk);
    redirect_valid = 1'b0; icache_valid = 1'b0; icache_data = 64'h0;
    chk("stale_dropped_count", 64'(queue_count), 64'd0);
    chk("stale_dropped_valid", 64'(out_valid), 64'd0);
    accept_line(32'h300, 2'b11, {32'hC0DE_0304, 32'hC0DE_0300}, 32'h300, 1'b1, 1'b1);

    // Reset with a full queue clears state asynchronously
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    accept_line(32'h308, 2'b11, 64'h0, 32'h0, 1'b0, 1'b0);
    accept_line(32'h310, 2'b11, 64'h0, 32'h0, 1'b0, 1'b0);
    accept_line(32'h318, 2'b11, 64'h0, 32'h0, 1'b0, 1'b0);
    accept_line(32'h320, 2'b11, 64'h0, 32'h0, 1'b0, 1'b0);
    chk("prereset_count", 64'(queue_count), 64'd4);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_count", 64'(queue_count), 64'd0);
    chk("async_rst_req", 64'(icache_req), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    accept_line(32'h0, 2'b11, {32'hC0DE_0004, 32'hC0DE_0000}, 32'h0, 1'b1, 1'b1);

`ifdef FETCH_PC_OUT_EN
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h204;
    @(negedge clk);
    redirect_valid = 1'b0;
    accept_line(32'h200, 2'b01, {32'h0, 32'hC0DE_0204}, 32'h204, 1'b1, 1'b0);
    accept_line(32'h208, 2'b11, {32'hC0DE_020C, 32'hC0DE_0208}, 32'h208, 1'b1, 1'b0);
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
